// File: rtl/bcd_xs3_seq_ctrl.sv
// Sequencer that converts a packed multi-digit BCD word to excess-3 one digit per cycle, LSD first.
// Optional saturating error-word counter on port err_count, enabled by defining BCD_ERR_CNT_EN.
module bcd_xs3_seq_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_bcd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_xs3,
   output logic                  out_err,
   output logic [DIGITS-1:0]     digit_err,
   output logic                  busy
`ifdef BCD_ERR_CNT_EN
   ,
   output logic [7:0]            err_count
`endif
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [IDX_W-1:0]    idx;
   logic [4*DIGITS-1:0] bcd_p0;
   logic                load;
   logic                step;
   logic [4:0]          conv_res;

   // Result packed as {err, xs3}; illegal digits map to 0000 with the error bit set.
   function automatic logic [4:0] xs3_conv(input logic [3:0] d);
      if (d > 4'd9) begin
         return 5'b1_0000;
      end
      return {1'b0, d + 4'd3};
   endfunction

`ifdef BCD_ERR_CNT_EN
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load      = 1'b1;
               state_nxt = CONV;
            end
         end
         CONV: begin
            busy = 1'b1;
            step = 1'b1;
            if (idx == LAST_IDX) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Stage p0: captured source word, only meaningful while converting.
   always_ff @(posedge clk) begin
      if (load) begin
         bcd_p0 <= in_bcd;
      end
   end

   assign conv_res = xs3_conv(bcd_p0[idx*4 +: 4]);

   always_ff @(posedge clk) begin
      if (rst || load) begin
         idx       <= '0;
         out_xs3   <= '0;
         digit_err <= '0;
      end else if (step) begin
         out_xs3[idx*4 +: 4] <= conv_res[3:0];
         digit_err[idx]      <= conv_res[4];
         if (idx != LAST_IDX) begin
            idx <= idx + 1'b1;
         end
      end
   end

   assign out_err = |digit_err;

`ifdef BCD_ERR_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= '0;
      end else if (out_valid && out_ready && out_err) begin
         err_count <= sat_inc8(err_count);
      end
   end
`endif

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Directed self-checking bench for bcd_xs3_seq_ctrl (DIGITS=4); err_count checks under BCD_ERR_CNT_EN.
module tb_bcd_xs3_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_bcd;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_xs3;
   logic        out_err;
   logic [3:0]  digit_err;
   logic        busy;
`ifdef BCD_ERR_CNT_EN
   logic [7:0]  err_count;
`endif

   int total;
   int bad;

   bcd_xs3_seq_ctrl #(.DIGITS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bcd    (in_bcd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_xs3   (out_xs3),
      .out_err   (out_err),
      .digit_err (digit_err),
      .busy      (busy)
`ifdef BCD_ERR_CNT_EN
      ,
      .err_count (err_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one word for a single accept edge, then count edges until out_valid (bounded).
   task automatic send_word(input logic [15:0] w, output int lat);
      in_bcd   = w;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_bcd = '0; out_ready = 1'b0;
      tick(); tick();
      total++;
      if ({out_valid, out_xs3, out_err, digit_err, busy} !== 23'd0) begin
         bad++;
         $display("FAIL reset_outputs got v=%b x=%h e=%b d=%b b=%b exp all zero", out_valid, out_xs3, out_err, digit_err, busy);
      end
      rst = 1'b0;
      tick();
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready got=%b exp=1", in_ready);
      end
   endtask

   task automatic test_basic(input logic [15:0] w, input logic [15:0] exp_x, input logic [3:0] exp_d, input string name);
      int lat;
      out_ready = 1'b1;
      send_word(w, lat);
      total++;
      if (lat !== 4) begin
         bad++;
         $display("FAIL %s_latency got=%0d exp=4", name, lat);
      end
      total++;
      if (out_xs3 !== exp_x || digit_err !== exp_d || out_err !== (|exp_d)) begin
         bad++;
         $display("FAIL %s_data got x=%h d=%b e=%b exp x=%h d=%b e=%b", name, out_xs3, digit_err, out_err, exp_x, exp_d, |exp_d);
      end
      total++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL %s_done_flags got busy=%b in_ready=%b exp 1 0", name, busy, in_ready);
      end
      tick();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_xs3 !== exp_x) begin
         bad++;
         $display("FAIL %s_release got v=%b r=%b x=%h exp 0 1 %h", name, out_valid, in_ready, out_xs3, exp_x);
      end
   endtask

   task automatic test_backpressure();
      int lat;
      int errs;
      out_ready = 1'b0;
      send_word(16'h5678, lat);
      errs = 0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         if (out_valid !== 1'b1 || out_xs3 !== 16'h89AB || in_ready !== 1'b0 || digit_err !== 4'b0000) errs++;
         tick();
      end
      in_valid = 1'b0;
      total++;
      if (errs !== 0) begin
         bad++;
         $display("FAIL backpressure_hold got bad_cycles=%0d exp=0 (x=%h)", errs, out_xs3);
      end
      out_ready = 1'b1;
      tick();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL backpressure_release got v=%b r=%b b=%b exp 0 1 0", out_valid, in_ready, busy);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      out_ready = 1'b1;
      in_bcd    = 16'h9876;
      in_valid  = 1'b1;
      tick();
      n = 1;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      in_valid = 1'b0;
      total++;
      if (n !== 6) begin
         bad++;
         $display("FAIL back_to_back_spacing got=%0d exp=6", n);
      end
      total++;
      if (out_xs3 !== 16'hCBA9 || out_err !== 1'b0) begin
         bad++;
         $display("FAIL back_to_back_data got x=%h e=%b exp x=cba9 e=0", out_xs3, out_err);
      end
   endtask

   task automatic test_reset_midflight();
      int seen;
      out_ready = 1'b1;
      in_bcd = 16'h4321;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_xs3 !== 16'h0000) begin
         bad++;
         $display("FAIL reset_conv got r=%b v=%b x=%h exp 1 0 0000", in_ready, out_valid, out_xs3);
      end
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid === 1'b1) seen++;
         tick();
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL reset_conv_no_valid got=%0d exp=0", seen);
      end
      out_ready = 1'b0;
      send_word(16'h0F00, seen);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || digit_err !== 4'b0000 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_done got r=%b v=%b d=%b b=%b exp 1 0 0000 0", in_ready, out_valid, digit_err, busy);
      end
   endtask

`ifdef BCD_ERR_CNT_EN
   task automatic test_err_count();
      int lat;
      out_ready = 1'b1;
      total++;
      if (err_count !== 8'h00) begin
         bad++;
         $display("FAIL err_count_start got=%h exp=00", err_count);
      end
      send_word(16'hF000, lat);
      total++;
      if (out_xs3 !== 16'h0333 || digit_err !== 4'b1000) begin
         bad++;
         $display("FAIL err_word_data got x=%h d=%b exp 0333 1000", out_xs3, digit_err);
      end
      tick();
      total++;
      if (err_count !== 8'h01) begin
         bad++;
         $display("FAIL err_count_one got=%h exp=01", err_count);
      end
      for (int i = 1; i < 300; i++) begin
         send_word(16'hF000, lat);
         tick();
      end
      total++;
      if (err_count !== 8'hFF) begin
         bad++;
         $display("FAIL err_count_sat got=%h exp=ff", err_count);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (err_count !== 8'h00) begin
         bad++;
         $display("FAIL err_count_reset got=%h exp=00", err_count);
      end
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_basic(16'h1234, 16'h4567, 4'b0000, "word_1234");
      test_basic(16'h0909, 16'h3C3C, 4'b0000, "word_0909");
      test_basic(16'h12A4, 16'h4507, 4'b0010, "word_12a4");
      test_basic(16'hFA90, 16'h00C3, 4'b1100, "word_fa90");
      test_backpressure();
      test_back_to_back();
      test_reset_midflight();
`ifdef BCD_ERR_CNT_EN
      test_err_count();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
